// File: rtl/auto_load_param_ctrl.sv
// Multi-bank auto-load controller: reads NBANKS parameter blocks from the PROM FIFO,
// optionally CRC-checks each with rewind/retry, then issues the PROM-to-FF load.
module auto_load_param_ctrl #(
   parameter int NWRDS     = 34,
   parameter int CRC_WRDS  = 2,
   parameter int NBANKS    = 2,
   parameter int MAX_ATMPT = 5,
   parameter int TMO_CYC   = 1023,
   parameter int BW        = (NBANKS > 1) ? $clog2(NBANKS) : 1,
   parameter int WCW       = $clog2(NWRDS + CRC_WRDS + 1)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CRC,
   input  logic              CRC_GOOD,
   input  logic              CRC_RDY,
   input  logic              PF_EMPTY,
   input  logic              XFER_DONE,
   input  logic              MAN_AL,
   input  logic              AUTO_XFER,
   output logic              AL_PF_RD,
   output logic              AL_RWND,
   output logic              CRC_DV,
   output logic              CLR_CRC,
   output logic              AL_PROM2FF,
   output logic [BW-1:0]     AL_BANK,
   output logic              AL_DONE,
   output logic [NBANKS-1:0] CRC_ERR,
   output logic [3:0]        AL_STATE
);

   localparam int TW = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
   localparam int AW = $clog2(MAX_ATMPT + 1);

   localparam logic [WCW-1:0] LIM_CRC    = WCW'(NWRDS + CRC_WRDS);
   localparam logic [WCW-1:0] LIM_RAW    = WCW'(NWRDS);
   localparam logic [AW-1:0]  LAST_ATMPT = AW'(MAX_ATMPT - 1);
   localparam logic [BW-1:0]  LAST_BANK  = BW'(NBANKS - 1);
   localparam logic [TW-1:0]  TMO_LAST   = TW'(TMO_CYC);

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      READ_FIFO  = 4'd1,
      STALL      = 4'd2,
      CRC_CALC   = 4'd3,
      CHK_CRC    = 4'd4,
      NEXT_ATMPT = 4'd5,
      NEXT_BANK  = 4'd6,
      WAIT4XFER  = 4'd7,
      START_XFER = 4'd8,
      SYNC       = 4'd9
   } state_t;

   state_t          state, nextstate, bank_done_st;
   logic [WCW-1:0]  wcnt, lim;
   logic [AW-1:0]   atmpt;
   logic [BW-1:0]   bank;
   logic [TW-1:0]   tmo;
   logic            set_err, clr_err;
   logic            pf_rd_d, rwnd_d, dv_d, clr_d, p2ff_d, done_d;

   assign lim     = CRC ? LIM_CRC : LIM_RAW;
   assign AL_BANK = bank;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= nextstate;
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      nextstate    = state;
      set_err      = 1'b0;
      clr_err      = 1'b0;
      bank_done_st = (bank == LAST_BANK) ? WAIT4XFER : NEXT_BANK;
      case (state)
         IDLE:       if (XFER_DONE) begin
                        clr_err   = 1'b1;
                        nextstate = PF_EMPTY ? STALL : READ_FIFO;
                     end
         READ_FIFO:  if (wcnt == lim)   nextstate = CRC ? CRC_CALC : bank_done_st;
                     else if (PF_EMPTY) nextstate = STALL;
         STALL:      if (!PF_EMPTY) nextstate = READ_FIFO;
         CRC_CALC:   nextstate = CHK_CRC;
         // A ready result always beats a timeout landing in the same cycle.
         CHK_CRC:    if (CRC_RDY && CRC_GOOD) nextstate = bank_done_st;
                     else if (CRC_RDY || tmo == TMO_LAST) begin
                        if (atmpt == LAST_ATMPT) begin
                           set_err   = 1'b1;
                           nextstate = bank_done_st;
                        end else begin
                           nextstate = NEXT_ATMPT;
                        end
                     end
         NEXT_ATMPT,
         NEXT_BANK:  nextstate = PF_EMPTY ? STALL : READ_FIFO;
         WAIT4XFER:  if (MAN_AL || (AUTO_XFER && CRC_ERR == '0)) nextstate = START_XFER;
         START_XFER: nextstate = SYNC;
         SYNC:       if (!XFER_DONE) nextstate = IDLE;
         default:    nextstate = IDLE;
      endcase
   end

   // Outputs are decoded from nextstate and registered, so they line up with their state.
   always_comb begin
      pf_rd_d = 1'b0;
      rwnd_d  = 1'b0;
      dv_d    = 1'b0;
      clr_d   = 1'b0;
      p2ff_d  = 1'b0;
      done_d  = 1'b0;
      case (nextstate)
         IDLE:       clr_d = 1'b1;
         READ_FIFO:  begin pf_rd_d = 1'b1; dv_d = 1'b1; end
         CRC_CALC:   dv_d = 1'b1;
         NEXT_ATMPT: begin clr_d = 1'b1; rwnd_d = 1'b1; end
         NEXT_BANK:  clr_d = 1'b1;
         WAIT4XFER:  done_d = 1'b1;
         START_XFER: p2ff_d = 1'b1;
         default:    ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         AL_PF_RD   <= 1'b0;
         AL_RWND    <= 1'b0;
         CRC_DV     <= 1'b0;
         CLR_CRC    <= 1'b0;
         AL_PROM2FF <= 1'b0;
         AL_DONE    <= 1'b0;
         AL_STATE   <= 4'd0;
         CRC_ERR    <= '0;
         wcnt       <= '0;
         atmpt      <= '0;
         bank       <= '0;
         tmo        <= '0;
      end else begin
         AL_PF_RD   <= pf_rd_d;
         AL_RWND    <= rwnd_d;
         CRC_DV     <= dv_d;
         CLR_CRC    <= clr_d;
         AL_PROM2FF <= p2ff_d;
         AL_DONE    <= done_d;
         AL_STATE   <= nextstate;

         // wcnt counts reads as they are issued, so it moves with the read strobe.
         case (nextstate)
            IDLE:       begin wcnt <= '0; atmpt <= '0; bank <= '0; end
            READ_FIFO:  wcnt <= wcnt + 1'b1;
            NEXT_ATMPT: begin wcnt <= '0; atmpt <= atmpt + 1'b1; end
            NEXT_BANK:  begin wcnt <= '0; atmpt <= '0; bank <= bank + 1'b1; end
            default:    ;
         endcase

         if (state == CRC_CALC)     tmo <= '0;
         else if (state == CHK_CRC) tmo <= tmo + 1'b1;

         if (clr_err)      CRC_ERR       <= '0;
         else if (set_err) CRC_ERR[bank] <= 1'b1;
      end
   end

endmodule

// File: doc/auto_load_param_ctrl.md
Name: auto_load_param_ctrl

Overview:
Multi-bank, parametrised successor to the single-bank auto-load parameter FSM. After the PROM-to-FIFO transfer completes, it reads NBANKS consecutive parameter blocks from the PROM FIFO and optionally CRC-checks each block. Failed blocks are retried via a FIFO rewind, with a timeout on the CRC checker. It reports per-bank CRC errors and issues the PROM-to-FF load either manually or automatically. Sits between the PROM FIFO / CRC engine and the parameter register file.

Parameters:
NWRDS, 34, payload words per bank
CRC_WRDS, 2, extra CRC words read per bank when CRC=1
NBANKS, 2, number of parameter banks (1..16)
MAX_ATMPT, 5, total read attempts per bank (>=1)
TMO_CYC, 1023, cycles in CHK_CRC without CRC_RDY before declaring failure
BW, derived, clog2(NBANKS) with minimum 1
WCW, derived, clog2(NWRDS+CRC_WRDS+1)

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
CRC  in  1  1 = banks carry CRC words and are checked
CRC_GOOD  in  1  CRC engine result, valid with CRC_RDY
CRC_RDY  in  1  CRC engine result valid
PF_EMPTY  in  1  PROM FIFO empty
XFER_DONE  in  1  PROM-to-FIFO transfer complete (level)
MAN_AL  in  1  manual load request
AUTO_XFER  in  1  1 = load automatically when all banks pass
AL_PF_RD  out  1  PROM FIFO read strobe
AL_RWND  out  1  one-cycle pulse: rewind FIFO read pointer to current bank start
CRC_DV  out  1  CRC engine data valid
CLR_CRC  out  1  CRC engine clear
AL_PROM2FF  out  1  one-cycle pulse: load parameters into FFs
AL_BANK  out  BW  bank currently being read
AL_DONE  out  1  all banks processed, waiting for load
CRC_ERR  out  NBANKS  sticky per-bank failure flags
AL_STATE  out  4  state encoding, for debug

Behaviour:
- All outputs are registered and decoded from nextstate, so they align with the state they belong to. On RST: state=IDLE, all outputs 0, all counters 0. A reset mid-operation aborts immediately with no pending pulses.
- Internal counters: wcnt (WCW bits, reads issued in the current attempt), atmpt (attempt index), bank (BW), tmo (clog2(TMO_CYC+1)). Unless a state below says otherwise, each counter is held.
- lim = CRC ? NWRDS+CRC_WRDS : NWRDS.
- States and encoding: IDLE=0, READ_FIFO=1, STALL=2, CRC_CALC=3, CHK_CRC=4, NEXT_ATMPT=5, NEXT_BANK=6, WAIT4XFER=7, START_XFER=8, SYNC=9. Codes 10-15 go to IDLE.
- IDLE: CLR_CRC=1; wcnt, atmpt and bank = 0. On XFER_DONE, clear CRC_ERR and go to READ_FIFO.
- READ_FIFO (entered only if a read is allowed): AL_PF_RD=1, CRC_DV=1, wcnt+1. Exit priority:
  - wcnt==lim: CRC ? CRC_CALC : bank-done.
  - PF_EMPTY: STALL.
  - otherwise: stay in READ_FIFO.
- STALL: no strobes. Return to READ_FIFO when !PF_EMPTY. No read is ever issued while PF_EMPTY=1.
- CRC_CALC: one cycle, CRC_DV=1, tmo=0, then CHK_CRC.
- CHK_CRC: tmo+1 each cycle. Exit priority:
  - CRC_RDY&&CRC_GOOD: bank-done.
  - (CRC_RDY&&!CRC_GOOD) or tmo==TMO_CYC: failure.
  - otherwise: stay.
  - Failure with atmpt==MAX_ATMPT-1: set CRC_ERR[bank], then bank-done. Failure otherwise: NEXT_ATMPT.
- NEXT_ATMPT: CLR_CRC=1, AL_RWND=1, atmpt+1, wcnt=0, then READ_FIFO (or STALL if PF_EMPTY).
- bank-done: bank==NBANKS-1 goes to WAIT4XFER; otherwise NEXT_BANK.
- NEXT_BANK: CLR_CRC=1, bank+1, atmpt=0, wcnt=0, then READ_FIFO (or STALL if PF_EMPTY).
- WAIT4XFER: AL_DONE=1. Go to START_XFER on MAN_AL, or on AUTO_XFER && CRC_ERR==0. MAN_AL overrides errors.
- START_XFER: AL_PROM2FF=1 for exactly one cycle, then SYNC.
- SYNC: wait for !XFER_DONE, then IDLE. Prevents a re-load while XFER_DONE is still high.
- Simultaneous-event rules:
  - CRC_RDY and timeout in the same cycle: CRC_RDY wins.
  - wcnt==lim and PF_EMPTY together: the lim exit wins.
- AL_BANK always equals the bank counter. CRC_ERR holds until the next IDLE-to-READ_FIFO transition.

Test Plan:
- CRC=0, NBANKS=2, PF never empty, XFER_DONE=1 -> exactly 68 AL_PF_RD pulses, CRC_DV never outside reads, AL_DONE=1, CRC_ERR=00; MAN_AL -> one AL_PROM2FF pulse; XFER_DONE=0 -> IDLE.
- CRC=1, bank 0 bad on the first check, then good -> 36 reads, AL_RWND pulse, 36 reads, then bank 1 with 36 reads; CRC_ERR=00; AUTO_XFER=1 -> AL_PROM2FF without MAN_AL.
- CRC=1, bank 1 always bad, MAX_ATMPT=5 -> bank 1 read 5 times, 4 AL_RWND pulses, CRC_ERR=10; AUTO_XFER=1 gives no load; MAN_AL then loads.
- CRC_RDY never asserted, TMO_CYC=1023 -> fail after 1024 CHK_CRC cycles, retries as a bad CRC.
- PF_EMPTY asserted for 10 cycles after read 7 -> no AL_PF_RD during STALL, total reads still 36 per bank.
- RST pulsed in READ_FIFO at wcnt=20 -> all outputs 0 asynchronously, state IDLE; the next XFER_DONE restarts from bank 0 with wcnt=0.
